// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep controller.
//   DEFAULT_WIDTH : default counter / bound width
//   state_e       : controller state encoding
package updown_sweep_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_UP     = 3'd3,
      ST_DOWN   = 3'd4,
      ST_FINISH = 3'd5
   } state_e;

endpackage : updown_sweep_ctrl_pkg

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an external loadable up/down counter.
// Produces lo->hi->lo sweeps (single or continuous) with start/stop control,
// a one-cycle done pulse and a sticky bad-bounds error flag.
//
// Ports:
//   clk          rising-edge clock
//   clear        asynchronous active-low reset
//   start        begin a sweep (accepted in IDLE only)
//   stop         abort a running sweep (UP/DOWN only)
//   mode         0 = single sweep, 1 = continuous (sampled at start)
//   lo, hi       sweep bounds (sampled at start, lo < hi required)
//   cnt_q        counter value feedback
//   cnt_d        counter load value
//   cnt_load     counter load enable
//   cnt_up_down  counter direction, 1 = up
//   cnt_clear_n  counter synchronous clear, active-low
//   busy         high in LOAD, UP, DOWN
//   dir          high in UP
//   done         one-cycle pulse in FINISH
//   err          sticky flag, set by a start with lo >= hi
module updown_sweep_ctrl
   import updown_sweep_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] cnt_q,
   output logic [WIDTH-1:0] cnt_d,
   output logic             cnt_load,
   output logic             cnt_up_down,
   output logic             cnt_clear_n,
   output logic             busy,
   output logic             dir,
   output logic             done,
   output logic             err
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] hi_r;
   logic             mode_r;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] hi_d;
   logic             mode_d;
   logic             err_d;

   // Next-cycle output values, registered below so every output is a flop.
   logic [WIDTH-1:0] cnt_d_d;
   logic             cnt_load_d;
   logic             cnt_up_down_d;
   logic             cnt_clear_n_d;
   logic             busy_d;
   logic             dir_d;
   logic             done_d;

   // Counter value after the coming edge, derived from what is driven now.
   // Lets the hold states present a registered cnt_d equal to the frozen q.
   logic [WIDTH-1:0] q_next;

   always_comb begin
      q_next = cnt_q;
      if (!cnt_clear_n) begin
         q_next = '0;
      end else if (cnt_load) begin
         q_next = cnt_d;
      end else if (cnt_up_down) begin
         q_next = cnt_q + WIDTH'(1);
      end else begin
         q_next = cnt_q - WIDTH'(1);
      end
   end

   // Next-state logic and bound capture.
   always_comb begin
      state_d = state_q;
      lo_d    = lo_r;
      hi_d    = hi_r;
      mode_d  = mode_r;
      err_d   = err;
      unique case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (start) begin
               if (lo < hi) begin
                  lo_d    = lo;
                  hi_d    = hi;
                  mode_d  = mode;
                  err_d   = 1'b0;
                  state_d = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_UP;
         end
         ST_UP: begin
            // stop outranks the turn-around at the upper bound
            if (stop) begin
               state_d = ST_FINISH;
            end else if (cnt_q == hi_r - WIDTH'(1)) begin
               state_d = ST_DOWN;
            end
         end
         ST_DOWN: begin
            if (stop) begin
               state_d = ST_FINISH;
            end else if (cnt_q == lo_r + WIDTH'(1)) begin
               state_d = mode_r ? ST_UP : ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Moore decode of the upcoming state.
   always_comb begin
      cnt_d_d       = q_next;
      cnt_load_d    = 1'b0;
      cnt_up_down_d = 1'b0;
      cnt_clear_n_d = 1'b1;
      busy_d        = 1'b0;
      dir_d         = 1'b0;
      done_d        = 1'b0;
      unique case (state_d)
         ST_INIT: begin
            cnt_clear_n_d = 1'b0;
            cnt_d_d       = '0;
         end
         ST_IDLE: begin
            cnt_load_d = 1'b1;
         end
         ST_LOAD: begin
            cnt_load_d = 1'b1;
            cnt_d_d    = lo_d;
            busy_d     = 1'b1;
         end
         ST_UP: begin
            cnt_up_down_d = 1'b1;
            busy_d        = 1'b1;
            dir_d         = 1'b1;
         end
         ST_DOWN: begin
            busy_d = 1'b1;
         end
         ST_FINISH: begin
            cnt_load_d = 1'b1;
            done_d     = 1'b1;
         end
         default: begin
            cnt_clear_n_d = 1'b0;
            cnt_d_d       = '0;
         end
      endcase
   end

   // State, bound and output registers.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q     <= ST_INIT;
         lo_r        <= '0;
         hi_r        <= '0;
         mode_r      <= 1'b0;
         err         <= 1'b0;
         cnt_d       <= '0;
         cnt_load    <= 1'b0;
         cnt_up_down <= 1'b0;
         cnt_clear_n <= 1'b0;
         busy        <= 1'b0;
         dir         <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_r        <= lo_d;
         hi_r        <= hi_d;
         mode_r      <= mode_d;
         err         <= err_d;
         cnt_d       <= cnt_d_d;
         cnt_load    <= cnt_load_d;
         cnt_up_down <= cnt_up_down_d;
         cnt_clear_n <= cnt_clear_n_d;
         busy        <= busy_d;
         dir         <= dir_d;
         done        <= done_d;
      end
   end

endmodule : updown_sweep_ctrl

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl wired back-to-back with an up/down counter.
// Expected per-cycle outputs come from a triangle-wave model of the sweep.
module tb_updown_sweep_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         clear;
   logic         start;
   logic         stop;
   logic         mode;
   logic [W-1:0] lo;
   logic [W-1:0] hi;
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         cnt_load;
   logic         cnt_up_down;
   logic         cnt_clear_n;
   logic         busy;
   logic         dir;
   logic         done;
   logic         err;

   typedef struct packed {
      logic [W-1:0] q;
      logic         clrn;
      logic         busy;
      logic         dir;
      logic         done;
      logic         err;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] cur_q;
   logic         cur_err;

   updown_sweep_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .stop        (stop),
      .mode        (mode),
      .lo          (lo),
      .hi          (hi),
      .cnt_q       (cnt_q),
      .cnt_d       (cnt_d),
      .cnt_load    (cnt_load),
      .cnt_up_down (cnt_up_down),
      .cnt_clear_n (cnt_clear_n),
      .busy        (busy),
      .dir         (dir),
      .done        (done),
      .err         (err)
   );

   // Loadable up/down counter datapath (sync clear has priority over load).
   always_ff @(posedge clk) begin
      if (!cnt_clear_n)     cnt_q <= '0;
      else if (cnt_load)    cnt_q <= cnt_d;
      else if (cnt_up_down) cnt_q <= cnt_q + W'(1);
      else                  cnt_q <= cnt_q - W'(1);
   end

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [W-1:0] q, input logic clrn,
                               input logic b, input logic d,
                               input logic dn, input logic e);
      exp_t r;
      r.q = q; r.clrn = clrn; r.busy = b; r.dir = d; r.done = dn; r.err = e;
      return r;
   endfunction

   // Counter value t cycles after entering UP: triangle with period 2*(hi-lo).
   function automatic logic [W-1:0] tri_q(input logic [W-1:0] l,
                                          input logic [W-1:0] h, input int t);
      int d, p;
      d = int'(h) - int'(l);
      p = t % (2 * d);
      return W'(int'(l) + ((p <= d) ? p : (2 * d - p)));
   endfunction

   // Single compare process: one expectation per cycle, checked mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = mk(cnt_q, cnt_clear_n, busy, dir, done, err);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle@%0t got q=%h clrn=%b busy=%b dir=%b done=%b err=%b want q=%h clrn=%b busy=%b dir=%b done=%b err=%b",
                     $time, a.q, a.clrn, a.busy, a.dir, a.done, a.err,
                     e.q, e.clrn, e.busy, e.dir, e.done, e.err);
         end
      end
   end

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, want);
      end
   endtask

   task automatic cyc(input exp_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(mk(cur_q, 1'b1, 1'b0, 1'b0, 1'b0, cur_err));
   endtask

   // One start request; stop_t / glitch_t / clr_t are sweep-cycle indices
   // (cycle 0 = first UP cycle), -1 disables.
   task automatic run_sweep(input logic [W-1:0] l, input logic [W-1:0] h,
                            input logic m, input int stop_t,
                            input int glitch_t, input int clr_t);
      logic [W-1:0] qv;
      int           d;
      logic         up;
      lo = l; hi = h; mode = m; start = 1'b1;
      cyc(mk(cur_q, 1'b1, 1'b0, 1'b0, 1'b0, cur_err));
      start = 1'b0;
      if (l >= h) begin
         cur_err = 1'b1;
         return;
      end
      cur_err = 1'b0;
      cyc(mk(cur_q, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      d = int'(h) - int'(l);
      for (int t = 0; t < 4096; t++) begin
         qv = tri_q(l, h, t);
         up = ((t % (2 * d)) < d);
         if (t == clr_t) begin
            clear = 1'b0;
            cyc(mk(qv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            cyc(mk(W'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            clear = 1'b1;
            cyc(mk(W'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            cur_q = '0;
            cur_err = 1'b0;
            return;
         end
         if (t == glitch_t) begin
            start = 1'b1; lo = 8'h00; hi = 8'h50; mode = ~m;
         end
         if (t == stop_t) stop = 1'b1;
         cyc(mk(qv, 1'b1, 1'b1, up, 1'b0, 1'b0));
         start = 1'b0;
         stop  = 1'b0;
         if (t == stop_t) begin
            cur_q = tri_q(l, h, t + 1);
            break;
         end
         if (!m && t == 2 * d - 1) begin
            cur_q = l;
            break;
         end
      end
      cyc(mk(cur_q, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
   endtask

   initial begin
      clk = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
      lo = '0; hi = '0; cur_q = '0; cur_err = 1'b0;

      // reset held, counter cleared by the INIT clear strobe
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      clear = 1'b1;
      cyc(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("idle_after_reset_q", int'(cnt_q), 'h00);
      chk("idle_after_reset_clrn", int'(cnt_clear_n), 1);

      // stop in IDLE is ignored
      stop = 1'b1; idle(2); stop = 1'b0; idle(1);

      // single sweep 03..06..03 with a start glitch mid-sweep
      run_sweep(8'h03, 8'h06, 1'b0, -1, 2, -1);
      idle(2);
      chk("single_end_q", int'(cnt_q), 'h03);
      chk("single_end_done", int'(done), 0);

      // continuous 10/11, stop while q=11 (DOWN)
      run_sweep(8'h10, 8'h11, 1'b1, 3, -1, -1);
      idle(2);
      chk("toggle_stop_q", int'(cnt_q), 'h10);

      // bad bounds: err set, no sweep
      run_sweep(8'h20, 8'h20, 1'b0, -1, -1, -1);
      idle(2);
      chk("bad_bounds_err", int'(err), 1);
      chk("bad_bounds_busy", int'(busy), 0);
      chk("bad_bounds_q", int'(cnt_q), 'h10);

      // full range single sweep clears err, no wrap
      run_sweep(8'h00, 8'hFF, 1'b0, -1, -1, -1);
      idle(2);
      chk("full_sweep_q", int'(cnt_q), 'h00);
      chk("full_sweep_err", int'(err), 0);

      // stop coincident with the upper turn-around (q=05, hi=06)
      run_sweep(8'h03, 8'h06, 1'b1, 2, -1, -1);
      idle(2);
      chk("stop_prio_q", int'(cnt_q), 'h06);

      // continuous full range, reset mid-DOWN at q=80
      run_sweep(8'h00, 8'hFF, 1'b1, -1, -1, 382);
      idle(3);
      chk("post_reset_q", int'(cnt_q), 'h00);
      chk("post_reset_busy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_updown_sweep_ctrl
